// File: rtl/enc_seq_if.sv
// Handshake bundle for enc_seq: vector input channel, index output channel and busy flag.
// The DUT attaches through the slave modport; the producer/consumer side uses master.
interface enc_seq_if #(
   parameter int N = 16
);
   localparam int W = $clog2(N);

   logic         i_in_vld;
   logic [N-1:0] i_in_vec;
   logic         o_in_rdy;
   logic         o_out_vld;
   logic [W-1:0] o_out_idx;
   logic         o_out_last;
   logic         i_out_rdy;
   logic         o_busy;

   modport master (
      output i_in_vld,
      output i_in_vec,
      output i_out_rdy,
      input  o_in_rdy,
      input  o_out_vld,
      input  o_out_idx,
      input  o_out_last,
      input  o_busy
   );

   modport slave (
      input  i_in_vld,
      input  i_in_vec,
      input  i_out_rdy,
      output o_in_rdy,
      output o_out_vld,
      output o_out_idx,
      output o_out_last,
      output o_busy
   );
endinterface

// File: rtl/enc_seq.sv
// Sequential bit-vector to binary encoder: walks the set bits of an accepted vector, lowest first.
// Optional macro ENC_SEQ_PIPE_EN lets the next vector enter on the same edge as the last index leaves.
module enc_seq #(
   parameter int N = 16
) (
   input  logic    i_clk,
   input  logic    i_arst_n,
   enc_seq_if.slave bus
);
   localparam int W = $clog2(N);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      ITER = 1'b1
   } state_t;

   state_t       state;
   state_t       next_state;
   logic [N-1:0] pnd;
   logic [N-1:0] next_pnd;
   logic [W-1:0] low_idx;
   logic         single;

   // Priority encoder on the registered pending mask; highest index scanned first so the lowest wins.
   always_comb begin
      low_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pnd[i]) low_idx = W'(i);
      end
   end

   assign single = (pnd != '0) && ((pnd & (pnd - ONE)) == '0);

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state <= IDLE;
         pnd   <= '0;
      end else begin
         state <= next_state;
         pnd   <= next_pnd;
      end
   end

   // Retiring an index clears the lowest set bit, which is exactly the one being presented.
   always_comb begin
      next_state     = state;
      next_pnd       = pnd;
      bus.o_in_rdy   = 1'b0;
      bus.o_out_vld  = 1'b0;
      bus.o_out_idx  = '0;
      bus.o_out_last = 1'b0;
      bus.o_busy     = 1'b0;
      case (state)
         IDLE: begin
            bus.o_in_rdy = 1'b1;
            if (bus.i_in_vld && (bus.i_in_vec != '0)) begin
               next_pnd   = bus.i_in_vec;
               next_state = ITER;
            end
         end
         ITER: begin
            bus.o_out_vld  = 1'b1;
            bus.o_busy     = 1'b1;
            bus.o_out_idx  = low_idx;
            bus.o_out_last = single;
`ifdef ENC_SEQ_PIPE_EN
            bus.o_in_rdy   = bus.i_out_rdy & single;
`endif
            if (bus.i_out_rdy) begin
               next_pnd = pnd & (pnd - ONE);
               if (single) begin
                  next_state = IDLE;
`ifdef ENC_SEQ_PIPE_EN
                  if (bus.i_in_vld) begin
                     next_pnd   = bus.i_in_vec;
                     next_state = (bus.i_in_vec != '0) ? ITER : IDLE;
                  end
`endif
               end
            end
         end
         default: begin
            next_state = IDLE;
            next_pnd   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_enc_seq.sv
// Scoreboard bench for enc_seq: directed scenarios plus randomized vectors with random backpressure.
module tb_enc_seq;
   localparam int N = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   enc_seq_if #(.N(N)) bus ();
   enc_seq_if #(.N(5)) bus5 ();

   enc_seq #(.N(N)) dut (
      .i_clk    (clk),
      .i_arst_n (rst_n),
      .bus      (bus.slave)
   );

   enc_seq #(.N(5)) dut5 (
      .i_clk    (clk),
      .i_arst_n (rst_n),
      .bus      (bus5.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      bit last;
   } beat_t;

   beat_t expQ[$];
   int    checks    = 0;
   int    errors    = 0;
   int    beatCount = 0;
   bit    randRdy   = 1'b0;
   bit    holdV     = 1'b0;
   int    holdIdx   = 0;
   bit    holdLast  = 1'b0;

   task automatic checkOutput(string name, int actual, int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference: the indices of the set bits in ascending order, the highest flagged as last.
   function automatic void pushExpected(logic [N-1:0] vec);
      int    idxs[$];
      beat_t b;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idxs.push_back(i);
      end
      foreach (idxs[k]) begin
         b.idx  = idxs[k];
         b.last = (k == idxs.size() - 1);
         expQ.push_back(b);
      end
   endfunction

   // Called just after a rising edge; returns just after the edge that accepted the vector.
   task automatic applyStimulus(logic [N-1:0] vec);
      bit done = 1'b0;
      bus.i_in_vld = 1'b1;
      bus.i_in_vec = vec;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (bus.o_in_rdy) begin
            pushExpected(vec);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.i_in_vld = 1'b0;
      bus.i_in_vec = N'($urandom);
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL input_handshake_timeout: got no o_in_rdy, expected acceptance of %h", vec);
      end
   endtask

   always @(posedge clk) begin
      if (randRdy) begin
         #1;
         bus.i_out_rdy = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard on every output handshake and checks stability under backpressure.
   always @(negedge clk) begin
      if (!rst_n) begin
         holdV = 1'b0;
      end else begin
         checkOutput("busy_vs_vld", int'(bus.o_busy), int'(bus.o_out_vld));
         if (!bus.o_out_vld) checkOutput("idx_when_invalid", int'(bus.o_out_idx), 0);
         if (holdV) begin
            checkOutput("held_idx", int'(bus.o_out_idx), holdIdx);
            checkOutput("held_last", int'(bus.o_out_last), int'(holdLast));
         end
         if (bus.o_out_vld) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat: got idx %0d, expected no output", bus.o_out_idx);
            end else if (bus.i_out_rdy) begin
               beat_t b;
               b = expQ.pop_front();
               checkOutput("out_idx", int'(bus.o_out_idx), b.idx);
               checkOutput("out_last", int'(bus.o_out_last), int'(b.last));
               beatCount++;
            end
         end
         holdV    = bus.o_out_vld && !bus.i_out_rdy;
         holdIdx  = int'(bus.o_out_idx);
         holdLast = bus.o_out_last;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  base;
      logic [N-1:0] vec;
      bit  pipe;
`ifdef ENC_SEQ_PIPE_EN
      pipe = 1'b1;
`else
      pipe = 1'b0;
`endif
      bus.i_in_vld   = 1'b0;
      bus.i_in_vec   = '0;
      bus.i_out_rdy  = 1'b0;
      bus5.i_in_vld  = 1'b0;
      bus5.i_in_vec  = '0;
      bus5.i_out_rdy = 1'b1;

      #3;
      checkOutput("rst_vld", int'(bus.o_out_vld), 0);
      checkOutput("rst_idx", int'(bus.o_out_idx), 0);
      checkOutput("rst_last", int'(bus.o_out_last), 0);
      checkOutput("rst_busy", int'(bus.o_busy), 0);
      checkOutput("rst_in_rdy", int'(bus.o_in_rdy), 1);
      checkOutput("rst_in_rdy_n5", int'(bus5.o_in_rdy), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Three indices on consecutive cycles, then ready for the next vector.
      bus.i_out_rdy = 1'b1;
      applyStimulus(8'b1010_0100);
      repeat (3) begin
         @(negedge clk);
         checkOutput("t1_vld", int'(bus.o_out_vld), 1);
      end
      @(negedge clk);
      checkOutput("t1_vld_after", int'(bus.o_out_vld), 0);
      checkOutput("t1_in_rdy_after", int'(bus.o_in_rdy), 1);
      @(posedge clk);
      #1;

      applyStimulus(8'h00);
      repeat (3) begin
         @(negedge clk);
         checkOutput("t2_vld", int'(bus.o_out_vld), 0);
         checkOutput("t2_busy", int'(bus.o_busy), 0);
         checkOutput("t2_in_rdy", int'(bus.o_in_rdy), 1);
      end
      @(posedge clk);
      #1;

      bus.i_out_rdy = 1'b0;
      applyStimulus(8'h03);
      repeat (3) begin
         @(negedge clk);
         checkOutput("t3_hold_vld", int'(bus.o_out_vld), 1);
         checkOutput("t3_hold_idx", int'(bus.o_out_idx), 0);
         checkOutput("t3_hold_last", int'(bus.o_out_last), 0);
      end
      @(posedge clk);
      #1;
      bus.i_out_rdy = 1'b1;
      @(negedge clk);
      checkOutput("t3_idx0", int'(bus.o_out_idx), 0);
      @(negedge clk);
      checkOutput("t3_idx1", int'(bus.o_out_idx), 1);
      checkOutput("t3_last1", int'(bus.o_out_last), 1);
      @(negedge clk);
      checkOutput("t3_done_vld", int'(bus.o_out_vld), 0);
      @(posedge clk);
      #1;

      // Non-power-of-two width: top bit of a 5-bit vector.
      bus5.i_in_vld = 1'b1;
      bus5.i_in_vec = 5'b10000;
      @(negedge clk);
      checkOutput("t4_in_rdy", int'(bus5.o_in_rdy), 1);
      @(posedge clk);
      #1;
      bus5.i_in_vld = 1'b0;
      @(negedge clk);
      checkOutput("t4_vld", int'(bus5.o_out_vld), 1);
      checkOutput("t4_idx", int'(bus5.o_out_idx), 4);
      checkOutput("t4_last", int'(bus5.o_out_last), 1);
      @(negedge clk);
      checkOutput("t4_idle_vld", int'(bus5.o_out_vld), 0);
      checkOutput("t4_idle_rdy", int'(bus5.o_in_rdy), 1);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a vector.
      base = beatCount;
      applyStimulus(8'hFF);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (beatCount >= base + 2) break;
      end
      checkOutput("t5_beats_before_reset", beatCount - base, 2);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_vld", int'(bus.o_out_vld), 0);
      checkOutput("t5_rst_busy", int'(bus.o_busy), 0);
      checkOutput("t5_rst_in_rdy", int'(bus.o_in_rdy), 1);
      checkOutput("t5_rst_idx", int'(bus.o_out_idx), 0);
      expQ.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkOutput("t5_no_beats", int'(bus.o_out_vld), 0);
      end
      @(posedge clk);
      #1;

      // Back-to-back single-bit vectors: bubble only without the pipelined option.
      applyStimulus(8'h01);
      fork
         applyStimulus(8'h02);
         begin
            @(negedge clk);
            checkOutput("t6_cycle1_vld", int'(bus.o_out_vld), 1);
            @(negedge clk);
            checkOutput("t6_cycle2_vld", int'(bus.o_out_vld), pipe ? 1 : 0);
            @(negedge clk);
            checkOutput("t6_cycle3_vld", int'(bus.o_out_vld), pipe ? 0 : 1);
         end
      join
      @(posedge clk);
      #1;

      randRdy = 1'b1;
      for (int v = 0; v < 200; v++) begin
         case ($urandom_range(0, 3))
            0:       vec = N'(1) << $urandom_range(0, N - 1);
            1:       vec = N'($urandom) & N'($urandom);
            default: vec = N'($urandom);
         endcase
         applyStimulus(vec);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      randRdy = 1'b0;
      @(posedge clk);
      #2;
      bus.i_out_rdy = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (expQ.size() == 0 && !bus.o_out_vld) break;
      end
      checkOutput("drain_queue_empty", expQ.size(), 0);
      checkOutput("drain_busy", int'(bus.o_busy), 0);
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
